// File: rtl/envelope_gen.sv
// envelope_gen: ADSR envelope generator with a signed sample multiplier.
// Define ENVELOPE_EXP_DECAY_EN for piecewise-exponential decay/release.
module envelope_gen #(
  parameter int OUTPUT_BITS = 12,
  parameter int ENV_BITS = 8,
  parameter int PRESCALE_SHIFT = 4
) (
  input  logic main_clk,
  input  logic reset_n,
  input  logic gate,
  input  logic [3:0] attack_rate,
  input  logic [3:0] decay_rate,
  input  logic [3:0] release_rate,
  input  logic [3:0] sustain_level,
  input  logic sample_en,
  input  logic signed [OUTPUT_BITS-1:0] wave_in,
  output logic signed [OUTPUT_BITS-1:0] out,
  output logic out_valid,
  output logic [ENV_BITS-1:0] env_level,
  output logic [2:0] env_state
);
  localparam int CW = PRESCALE_SHIFT + 8;
  localparam int PW = OUTPUT_BITS + ENV_BITS + 1;
  localparam logic [ENV_BITS-1:0] FULL = '1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } state_t;

  state_t state;
  logic gate_q;
  logic [CW-1:0] cnt;
  logic [CW-1:0] period;
  logic [CW-1:0] last;
  logic [3:0] rate;
  logic rise, fall, tick;
  logic [ENV_BITS-1:0] target;
  logic [ENV_BITS-1:0] lvl_dn;
  logic signed [PW-1:0] wave_x;
  logic signed [PW-1:0] lvl_x;
  logic signed [PW-1:0] prod;

  assign rise = gate & ~gate_q;
  assign fall = ~gate & gate_q;
  assign env_state = state;
  assign target = ENV_BITS'({4'd0, sustain_level} * 8'd17);
  assign lvl_dn = env_level - 1'b1;
  assign tick = (cnt >= last);

  always_comb begin
    unique case (1'b1)
      state == ATTACK: rate = attack_rate;
      state == DECAY:  rate = decay_rate;
      default:         rate = release_rate;
    endcase
    period = CW'({1'b0, rate} + 5'd1) << PRESCALE_SHIFT;
`ifdef ENVELOPE_EXP_DECAY_EN
    // Slower steps at low levels approximate an exponential tail
    if (state != ATTACK) begin
      if (env_level < ENV_BITS'(32))
        period = period << 3;
      else if (env_level < ENV_BITS'(64))
        period = period << 2;
      else if (env_level < ENV_BITS'(128))
        period = period << 1;
    end
`endif
    last = period - CW'(1);
  end

  always_ff @(posedge main_clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      env_level <= '0;
      cnt       <= '0;
      gate_q    <= 1'b0;
    end else begin
      gate_q <= gate;
      if (rise) begin
        state <= ATTACK;
        cnt   <= '0;
      end else if (fall && (state == ATTACK ||
                            state == DECAY ||
                            state == SUSTAIN)) begin
        state <= RELEASE;
        cnt   <= '0;
      end else begin
        unique case (1'b1)
          state == ATTACK: begin
            if (env_level == FULL) begin
              state <= DECAY;
              cnt   <= '0;
            end else if (tick) begin
              cnt       <= '0;
              env_level <= env_level + 1'b1;
              if (env_level == FULL - 1'b1)
                state <= DECAY;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          state == DECAY: begin
            if (env_level <= target) begin
              state <= SUSTAIN;
              cnt   <= '0;
            end else if (tick) begin
              cnt       <= '0;
              env_level <= lvl_dn;
              if (lvl_dn <= target)
                state <= SUSTAIN;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          state == RELEASE: begin
            if (env_level == '0) begin
              state <= IDLE;
              cnt   <= '0;
            end else if (tick) begin
              cnt       <= '0;
              env_level <= lvl_dn;
              if (lvl_dn == '0)
                state <= IDLE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign wave_x = PW'(wave_in);
  assign lvl_x  = PW'(env_level);
  assign prod   = wave_x * lvl_x;

  always_ff @(posedge main_clk or negedge reset_n) begin
    if (!reset_n) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= sample_en;
      if (sample_en)
        out <= OUTPUT_BITS'(prod >>> ENV_BITS);
    end
  end
endmodule

// File: doc/envelope_gen.md
ENVELOPE_GEN -- requirements
Module: envelope_gen

Interface
- REQ-001 SHALL have parameter OUTPUT_BITS, default 12: sample width of wave_in and out.
- REQ-002 SHALL have parameter ENV_BITS, default 8: envelope level width, with full scale 255.
- REQ-003 SHALL have parameter PRESCALE_SHIFT, default 4: rate prescale exponent.
- REQ-004 SHALL have port main_clk, input, 1 bit: the single clock; all state updates on its rising edge.
- REQ-005 SHALL have port reset_n, input, 1 bit: reset, asynchronous, active-low.
- REQ-006 SHALL have port gate, input, 1 bit: note on (1) / note off (0), sampled each cycle.
- REQ-007 SHALL have ports attack_rate, decay_rate and release_rate, each an input, 4 bits: rate nibbles.
- REQ-008 SHALL have port sustain_level, input, 4 bits: sustain target = sustain_level*17.
- REQ-009 SHALL have port sample_en, input, 1 bit: one-cycle sample strobe for wave_in.
- REQ-010 SHALL have port wave_in, input, signed OUTPUT_BITS: oscillator sample.
- REQ-011 SHALL have port out, output, signed OUTPUT_BITS: enveloped sample.
- REQ-012 SHALL have port out_valid, output, 1 bit: one-cycle pulse when out updates.
- REQ-013 SHALL have port env_level, output, ENV_BITS: current envelope level.
- REQ-014 SHALL have port env_state, output, 3 bits: encoded as IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.

Function
- REQ-015 SHALL register gate into gate_q and detect rise = gate & ~gate_q and fall = ~gate & gate_q.
- REQ-016 SHALL derive step period P = (rate+1) << PRESCALE_SHIFT cycles, selecting rate by state (attack/decay/release); default P is 16..256.
- REQ-017 SHALL use a prescale counter that increments every cycle in ATTACK/DECAY/RELEASE; on reaching P-1 it SHALL clear and apply one level step (+1 in ATTACK, -1 in DECAY/RELEASE).
- REQ-018 SHALL, on rise in any state, enter ATTACK next cycle with the prescale counter cleared and the level unchanged (no retrigger to 0).
- REQ-019 SHALL, in ATTACK, when a step brings the level to 255, enter DECAY at that edge; the level SHALL never exceed 255.
- REQ-020 SHALL, in DECAY, when level <= target, enter SUSTAIN; if target >= level on entry, SHALL enter SUSTAIN the next cycle with no step.
- REQ-021 SHALL, in SUSTAIN, hold the level and the counter; a sustain_level change SHALL NOT alter the level.
- REQ-022 SHALL, on fall in ATTACK/DECAY/SUSTAIN, enter RELEASE with the counter cleared.
- REQ-023 SHALL, in RELEASE, when the level reaches 0, enter IDLE; the level SHALL never underflow.
- REQ-024 SHALL give rise priority over any same-cycle step completion; a rise and fall in the same cycle is impossible.
- REQ-025 SHALL make rate nibble changes take effect at the next counter comparison; if the counter is >= the new P-1, it SHALL step immediately.
- REQ-026 SHALL, on sample_en, register out = (wave_in * {0,env_level}) >>> 8 as a signed product, truncated to OUTPUT_BITS.
- REQ-027 SHALL assert out_valid one cycle after sample_en, for exactly 1 cycle.
- REQ-028 SHALL make level 255 yield out = wave_in*255/256 (floor) and level 0 yield out = 0.

Reset
- REQ-029 SHALL, while reset_n=0, force state=IDLE, env_level=0, counter=0, gate_q=0, out=0 and out_valid=0, independent of main_clk.
- REQ-030 SHALL treat a gate held high at reset release as a rise on the first clock after release.
- REQ-031 SHALL make reset mid-ATTACK/RELEASE abort the envelope immediately, with no residual step.

Configuration
- REQ-032 SHALL, with macro ENVELOPE_EXP_DECAY_EN defined, multiply P in DECAY/RELEASE by 2 when level < 128, 4 when < 64 and 8 when < 32 (piecewise exponential); ATTACK SHALL stay linear.
- REQ-033 SHALL, with ENVELOPE_EXP_DECAY_EN undefined, keep all phases linear with no multiplier logic present.

Verification
- REQ-034 SHALL cover: attack_rate=0, gate 0->1 -> env_state=1 next cycle; level +1 every 16 cycles; level 255 after 4080 cycles then env_state=2.
- REQ-035 SHALL cover: decay_rate=0, sustain_level=8 -> level falls 255->136 (1904 cycles linear), then env_state=3 and the level holds for 1000 cycles.
- REQ-036 SHALL cover: gate 1->0 in SUSTAIN at level 136, release_rate=1 -> level -1 per 32 cycles; reaches 0 after 4352 cycles; env_state=0.
- REQ-037 SHALL cover: retrigger (gate rise) in RELEASE at level 50 -> ATTACK starting from 50, not 0.
- REQ-038 SHALL cover: level=128, wave_in=-2048, sample_en -> out=-1024 and out_valid=1 one cycle later; wave_in=2047 with level 255 -> out=2039.
- REQ-039 SHALL cover: reset_n=0 asserted asynchronously mid-ATTACK at level 100 -> level=0, env_state=0 and out=0 before the next clock edge.
